// File: rtl/axi_chan_fifo.sv
// -----------------------------------------------------------------------------
// axi_chan_fifo
//   Single-clock first-word-fall-through FIFO for one AXI channel payload.
//   Binary read/write pointers carry one extra wrap bit, so full and empty
//   are told apart without a separate occupancy register.
//
//   Optional feature: define AXI_CHAN_FIFO_ERR_EN to build sticky
//   overflow/underflow flags. Without it, err is tied to 2'b00 and no
//   error registers exist.
//
// Parameters
//   DATA_W   : payload width in bits (>= 1)
//   DEPTH    : entry count, power of two, >= 2
//   AFULL_TH : occupancy at or above which afull asserts (1..DEPTH)
//
// Ports
//   clk   in   single clock, rising edge
//   rstn  in   synchronous active-low reset (pointers and flags only)
//   push  in   write request
//   wdata in   write payload
//   full  out  no free entry
//   afull out  count >= AFULL_TH
//   pop   in   read request, consumes the head entry
//   rdata out  head entry (zero when empty)
//   empty out  no valid entry
//   count out  current occupancy, 0..DEPTH
//   err   out  sticky flags: [0] overflow, [1] underflow
// -----------------------------------------------------------------------------
module axi_chan_fifo #(
    parameter int unsigned DATA_W   = 45,
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned AFULL_TH = DEPTH - 1
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       push,
    input  logic [DATA_W-1:0]          wdata,
    output logic                       full,
    output logic                       afull,
    input  logic                       pop,
    output logic [DATA_W-1:0]          rdata,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count,
    output logic [1:0]                 err
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    logic [PW-1:0]     wptr_q, wptr_d;
    logic [PW-1:0]     rptr_q, rptr_d;
    logic [DATA_W-1:0] mem_q [DEPTH];

    logic we;
    logic re;

    // Status derived purely from the registered pointers.
    always_comb begin
        empty = (wptr_q == rptr_q);
        full  = (wptr_q[AW-1:0] == rptr_q[AW-1:0]) && (wptr_q[AW] != rptr_q[AW]);
        count = wptr_q - rptr_q;
        afull = (count >= PW'(AFULL_TH));
        rdata = empty ? '0 : mem_q[rptr_q[AW-1:0]];
    end

    // A pop frees the head slot in the same cycle, so a full FIFO may still
    // accept a push alongside it. Pop on empty is ignored even with a push.
    always_comb begin
        we     = rstn && push && (!full || pop);
        re     = rstn && pop && !empty;
        wptr_d = wptr_q + (we ? PW'(1) : PW'(0));
        rptr_d = rptr_q + (re ? PW'(1) : PW'(0));
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    // Storage is deliberately not reset; the pointers define validity.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[wptr_q[AW-1:0]] <= wdata;
        end
    end

`ifdef AXI_CHAN_FIFO_ERR_EN
    logic [1:0] err_q, err_d;

    always_comb begin
        err_d    = err_q;
        if (push && full && !pop) begin
            err_d[0] = 1'b1;
        end
        if (pop && empty) begin
            err_d[1] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            err_q <= 2'b00;
        end else begin
            err_q <= err_d;
        end
    end

    assign err = err_q;
`else
    assign err = 2'b00;
`endif

endmodule

// File: tb/tb_axi_chan_fifo.sv
// -----------------------------------------------------------------------------
// tb_axi_chan_fifo
//   Directed self-checking bench for axi_chan_fifo (DATA_W=45, DEPTH=4,
//   AFULL_TH=3). Expected err values follow AXI_CHAN_FIFO_ERR_EN.
// -----------------------------------------------------------------------------
module tb_axi_chan_fifo;

    logic        clk;
    logic        rstn;
    logic        push;
    logic [44:0] wdata;
    logic        full;
    logic        afull;
    logic        pop;
    logic [44:0] rdata;
    logic        empty;
    logic [2:0]  count;
    logic [1:0]  err;

    int tests_run;
    int tests_failed;

    axi_chan_fifo #(
        .DATA_W  (45),
        .DEPTH   (4),
        .AFULL_TH(3)
    ) dut (
        .clk  (clk),
        .rstn (rstn),
        .push (push),
        .wdata(wdata),
        .full (full),
        .afull(afull),
        .pop  (pop),
        .rdata(rdata),
        .empty(empty),
        .count(count),
        .err  (err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance one rising edge and settle away from it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rstn  = 1'b0;
        push  = 1'b0;
        pop   = 1'b0;
        wdata = '0;
        tick();
        tick();
        rstn = 1'b1;
        #1;
        tests_run++;
        if (empty !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_empty: got %0b expected 1", empty);
        end
        tests_run++;
        if (full !== 1'b0 || afull !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_full_afull: got %0b/%0b expected 0/0", full, afull);
        end
        tests_run++;
        if (count !== 3'd0) begin
            tests_failed++;
            $display("FAIL reset_count: got %0d expected 0", count);
        end
        tests_run++;
        if (rdata !== 45'h0) begin
            tests_failed++;
            $display("FAIL reset_rdata: got %0h expected 0", rdata);
        end
        tests_run++;
        if (err !== 2'b00) begin
            tests_failed++;
            $display("FAIL reset_err: got %b expected 00", err);
        end
    endtask

    task automatic test_fill();
        for (int i = 0; i < 4; i++) begin
            push  = 1'b1;
            wdata = 45'(i + 1);
            tick();
            tests_run++;
            if (count !== 3'(i + 1)) begin
                tests_failed++;
                $display("FAIL fill_count[%0d]: got %0d expected %0d", i, count, i + 1);
            end
            tests_run++;
            if (afull !== (i >= 2) || full !== (i == 3)) begin
                tests_failed++;
                $display("FAIL fill_flags[%0d]: got afull=%0b full=%0b expected afull=%0b full=%0b",
                         i, afull, full, (i >= 2), (i == 3));
            end
            tests_run++;
            if (rdata !== 45'h1) begin
                tests_failed++;
                $display("FAIL fill_rdata[%0d]: got %0h expected 1", i, rdata);
            end
        end
        push = 1'b0;
    endtask

    task automatic test_full_push_pop();
        logic [44:0] exp_d;
        push  = 1'b1;
        pop   = 1'b1;
        wdata = 45'h5;
        tick();
        push = 1'b0;
        pop  = 1'b0;
        tests_run++;
        if (count !== 3'd4 || full !== 1'b1) begin
            tests_failed++;
            $display("FAIL fullpp_count: got count=%0d full=%0b expected 4/1", count, full);
        end
        tests_run++;
        if (rdata !== 45'h2) begin
            tests_failed++;
            $display("FAIL fullpp_rdata: got %0h expected 2", rdata);
        end
        for (int i = 0; i < 4; i++) begin
            exp_d = 45'(i + 2);
            tests_run++;
            if (rdata !== exp_d) begin
                tests_failed++;
                $display("FAIL fullpp_drain[%0d]: got %0h expected %0h", i, rdata, exp_d);
            end
            pop = 1'b1;
            tick();
        end
        pop = 1'b0;
        tests_run++;
        if (empty !== 1'b1 || count !== 3'd0 || rdata !== 45'h0) begin
            tests_failed++;
            $display("FAIL fullpp_empty: got empty=%0b count=%0d rdata=%0h expected 1/0/0",
                     empty, count, rdata);
        end
    endtask

    task automatic test_wrap();
        logic [44:0] exp_d;
        exp_d = 45'h10;
        // Prime three entries, then run pairs at occupancy 3, then drain.
        for (int i = 0; i < 3; i++) begin
            push  = 1'b1;
            wdata = 45'(16 + i);
            tick();
        end
        for (int i = 3; i < 10; i++) begin
            tests_run++;
            if (rdata !== exp_d) begin
                tests_failed++;
                $display("FAIL wrap_pair[%0d]: got %0h expected %0h", i, rdata, exp_d);
            end
            exp_d++;
            push  = 1'b1;
            pop   = 1'b1;
            wdata = 45'(16 + i);
            tick();
        end
        push = 1'b0;
        tests_run++;
        if (count !== 3'd3) begin
            tests_failed++;
            $display("FAIL wrap_count: got %0d expected 3", count);
        end
        for (int i = 0; i < 3; i++) begin
            tests_run++;
            if (rdata !== exp_d) begin
                tests_failed++;
                $display("FAIL wrap_drain[%0d]: got %0h expected %0h", i, rdata, exp_d);
            end
            exp_d++;
            pop = 1'b1;
            tick();
        end
        pop = 1'b0;
        tests_run++;
        if (empty !== 1'b1 || exp_d !== 45'h1a) begin
            tests_failed++;
            $display("FAIL wrap_end: got empty=%0b next=%0h expected 1/1a", empty, exp_d);
        end
    endtask

    task automatic test_empty_push_pop();
        push  = 1'b1;
        pop   = 1'b1;
        wdata = 45'hA;
        tick();
        push = 1'b0;
        pop  = 1'b0;
        tests_run++;
        if (count !== 3'd1 || empty !== 1'b0) begin
            tests_failed++;
            $display("FAIL emptypp_count: got count=%0d empty=%0b expected 1/0", count, empty);
        end
        tests_run++;
        if (rdata !== 45'hA) begin
            tests_failed++;
            $display("FAIL emptypp_rdata: got %0h expected a", rdata);
        end
    endtask

    task automatic test_reset_mid();
        push  = 1'b1;
        wdata = 45'h77;
        tick();
        rstn  = 1'b0;
        pop   = 1'b1;
        wdata = 45'h88;
        tick();
        rstn = 1'b1;
        push = 1'b0;
        pop  = 1'b0;
        #1;
        tests_run++;
        if (empty !== 1'b1 || count !== 3'd0 || rdata !== 45'h0) begin
            tests_failed++;
            $display("FAIL reset_mid: got empty=%0b count=%0d rdata=%0h expected 1/0/0",
                     empty, count, rdata);
        end
    endtask

    task automatic test_errors();
        logic [1:0]  exp_ovf;
        logic [1:0]  exp_both;
        logic [44:0] exp_d;
`ifdef AXI_CHAN_FIFO_ERR_EN
        exp_ovf  = 2'b01;
        exp_both = 2'b11;
`else
        exp_ovf  = 2'b00;
        exp_both = 2'b00;
`endif
        for (int i = 0; i < 4; i++) begin
            push  = 1'b1;
            wdata = 45'(33 + i);
            tick();
        end
        wdata = 45'h99;
        tick();
        push = 1'b0;
        tests_run++;
        if (err !== exp_ovf) begin
            tests_failed++;
            $display("FAIL err_overflow: got %b expected %b", err, exp_ovf);
        end
        tests_run++;
        if (count !== 3'd4) begin
            tests_failed++;
            $display("FAIL err_ovf_count: got %0d expected 4", count);
        end
        for (int i = 0; i < 4; i++) begin
            exp_d = 45'(33 + i);
            tests_run++;
            if (rdata !== exp_d) begin
                tests_failed++;
                $display("FAIL err_contents[%0d]: got %0h expected %0h", i, rdata, exp_d);
            end
            pop = 1'b1;
            tick();
        end
        tick();
        pop = 1'b0;
        tests_run++;
        if (err !== exp_both || count !== 3'd0) begin
            tests_failed++;
            $display("FAIL err_underflow: got err=%b count=%0d expected %b/0",
                     err, count, exp_both);
        end
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        #1;
        tests_run++;
        if (err !== 2'b00) begin
            tests_failed++;
            $display("FAIL err_clear: got %b expected 00", err);
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        test_reset();
        test_fill();
        test_full_push_pop();
        test_wrap();
        test_empty_push_pop();
        test_reset_mid();
        test_errors();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/axi_chan_fifo.md
AXI_CHAN_FIFO -- requirements
Module: axi_chan_fifo

Interface
REQ-001 SHALL have parameter DATA_W, default 45, payload width in bits (>=1).
REQ-002 SHALL have parameter DEPTH, default 4, entry count; power of two, >=2.
REQ-003 SHALL have parameter AFULL_TH, default DEPTH-1, count at or above which afull asserts (1..DEPTH).
REQ-004 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-005 SHALL have port rstn  input  1  synchronous, active-low reset.
REQ-006 SHALL have port push  input  1  write request.
REQ-007 SHALL have port wdata  input  DATA_W  write payload.
REQ-008 SHALL have port full  output  1  no free entry.
REQ-009 SHALL have port afull  output  1  count >= AFULL_TH.
REQ-010 SHALL have port pop  input  1  read request; consumes the head entry.
REQ-011 SHALL have port rdata  output  DATA_W  head entry, first-word fall-through.
REQ-012 SHALL have port empty  output  1  no valid entry.
REQ-013 SHALL have port count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
REQ-014 SHALL have port err  output  2  sticky error flags: [0] overflow, [1] underflow.

Function
REQ-015 SHALL use binary write and read pointers of $clog2(DEPTH)+1 bits; low bits index storage, MSB is the wrap bit.
REQ-016 SHALL derive empty = (wptr == rptr), full = (index bits equal AND wrap bits differ), both combinational from registered pointers.
REQ-017 SHALL derive count = wptr - rptr, modulo 2^($clog2(DEPTH)+1).
REQ-018 SHALL accept a write (write enable) when push && (!full || pop); the write stores wdata at wptr index and increments wptr.
REQ-019 SHALL accept a read when pop && !empty; the read increments rptr.
REQ-020 SHALL, when full with push and pop together, perform both: count stays DEPTH, the head is replaced in order.
REQ-021 SHALL, when empty with push and pop together, perform the write only; pop is ignored, count becomes 1.
REQ-022 SHALL present rdata = storage[rptr index] when !empty, and all-zero when empty, with zero-cycle latency after the write cycle (data written at edge N is visible after edge N).
REQ-023 SHALL wrap both pointers naturally on overflow of the index bits; ordering is preserved across wrap.
REQ-024 SHALL ignore push when full and pop is 0 (no pointer or storage change); it SHALL ignore pop when empty.
REQ-025 SHALL not reset the storage array contents; only pointers and flags are reset.

Reset
REQ-026 SHALL, on rising clk edge with rstn==0, set wptr=0 and rptr=0, giving empty=1, full=0, afull=0, count=0, rdata=0, err=2'b00.
REQ-027 SHALL, on reset asserted mid-operation, discard all stored entries; push/pop in that cycle have no effect.

Configuration
REQ-028 SHALL compile sticky error detection when macro AXI_CHAN_FIFO_ERR_EN is defined: err[0] sets on push && full && !pop, err[1] sets on pop && empty, and both clear only on reset.
REQ-029 SHALL, without AXI_CHAN_FIFO_ERR_EN, tie err to 2'b00 and instantiate no error registers.

Verification (DATA_W=45, DEPTH=4, AFULL_TH=3)
REQ-030 Reset: rstn=0 for 2 cycles, then 1 -> empty=1, full=0, count=0, rdata=0, err=0.
REQ-031 Fill: push 0x1,0x2,0x3,0x4 on consecutive cycles -> count 1,2,3,4; afull=1 at count 3; full=1 after 4th; rdata=0x1 throughout.
REQ-032 Full push+pop: from full, push 0x5 with pop -> count stays 4, rdata=0x2; then drain 4 pops -> 0x2,0x3,0x4,0x5, then empty=1.
REQ-033 Wrap: 10 push/pop pairs of 0x10..0x19 with occupancy 1..3 -> output order 0x10..0x19 exact, no loss.
REQ-034 Empty push+pop: from empty, push 0xA with pop -> count=1, rdata=0xA next cycle.
REQ-035 Errors (macro defined): push with pop=0 when full -> err=2'b01, contents unchanged; pop when empty -> err=2'b11; rstn=0 -> err=0; macro undefined -> err stays 0.
